spi_slave_if: RTL and testbench

Serial front end for the single-port command RAM. It deserializes SPI frames on MOSI into 10-bit RAM command words and presents them on a one-cycle `rx_valid` strobe. For read-data frames it captures the RAM's `tx_data`/`tx_valid` reply and shifts it out on MISO. It sits between the external SPI master pins and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` ports.

---
 rtl/spi_slave_if.sv | 147 ++++++++++++++
 tb/tb_spi_slave_if.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// spi_slave_if : SPI slave front end for the command RAM (optional SPI_FRAME_ERR_EN)
// Rev 1.0
// ============================================================================
module spi_slave_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic            frame_err
`endif
);

  localparam int              c_TXC_W    = (TX_W > 1) ? $clog2(TX_W) : 1;
  localparam logic [3:0]      c_RX_LAST  = 4'(RX_W - 1);
  localparam logic [c_TXC_W-1:0] c_TX_LAST = c_TXC_W'(TX_W - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK_CMD   = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_ADD  = 3'd3,
    S_READ_DATA = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_bit_cnt;
  logic                 r_rx_done;
  logic [RX_W-1:0]      r_shift;
  logic [TX_W-1:0]      r_tx_shift;
  logic [c_TXC_W-1:0]   r_tx_cnt;
  logic                 r_tx_active;
  logic                 r_tx_done;
  logic                 r_rd_addr_seen;
  logic                 w_in_frame;
  logic                 w_in_rx;
  logic                 w_rx_last;
  logic                 w_tx_wait;
  logic                 w_tx_last;

  assign w_in_frame = (r_state == S_WRITE) || (r_state == S_READ_ADD) ||
                      (r_state == S_READ_DATA);
  assign w_in_rx    = w_in_frame && !r_rx_done;
  assign w_rx_last  = w_in_rx && (r_bit_cnt == c_RX_LAST);
  // Reply window opens the cycle after the strobe and closes once a reply is captured.
  assign w_tx_wait  = (r_state == S_READ_DATA) && r_rx_done && !r_tx_active && !r_tx_done;
  assign w_tx_last  = r_tx_active && (r_tx_cnt == c_TX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (SS_n) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_CHK_CMD;
        S_CHK_CMD: begin
          if (!MOSI)               w_next = S_WRITE;
          else if (r_rd_addr_seen) w_next = S_READ_DATA;
          else                     w_next = S_READ_ADD;
        end
        default:   w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= '0;
      r_rx_done      <= 1'b0;
      r_shift        <= '0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_tx_active    <= 1'b0;
      r_tx_done      <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      MISO           <= 1'b0;
    end else if (SS_n) begin
      // Frame closed or aborted: partial word dropped, flag left as is.
      r_bit_cnt   <= '0;
      r_rx_done   <= 1'b0;
      r_tx_cnt    <= '0;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
      rx_valid    <= 1'b0;
      MISO        <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (w_in_rx) begin
        r_shift   <= {r_shift[RX_W-2:0], MOSI};
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (w_rx_last) begin
          rx_data   <= {r_shift[RX_W-2:0], MOSI};
          rx_valid  <= 1'b1;
          r_rx_done <= 1'b1;
          if (r_state == S_READ_ADD) r_rd_addr_seen <= 1'b1;
        end
      end
      if (w_tx_wait && tx_valid) begin
        r_tx_active <= 1'b1;
        r_tx_cnt    <= '0;
        MISO        <= tx_data[TX_W-1];
        r_tx_shift  <= {tx_data[TX_W-2:0], 1'b0};
      end else if (r_tx_active) begin
        if (w_tx_last) begin
          r_tx_active    <= 1'b0;
          r_tx_done      <= 1'b1;
          MISO           <= 1'b0;
          r_rd_addr_seen <= 1'b0;
        end else begin
          MISO       <= r_tx_shift[TX_W-1];
          r_tx_shift <= {r_tx_shift[TX_W-2:0], 1'b0};
          r_tx_cnt   <= r_tx_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  // Early SS_n release: before the command strobe, or before a READ_DATA reply completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= SS_n && ((w_in_frame && !r_rx_done) ||
                                      ((r_state == S_READ_DATA) && !r_tx_done));
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// Self-checking bench for spi_slave_if: directed frames then randomized frames vs. a frame-level model.
module tb_spi_slave_if;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: has a read address been latched, and the last word delivered.
  bit         m_seen;
  logic [9:0] m_last_rx;

  spi_slave_if #(.RX_W(10), .TX_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input bit dir, input logic [9:0] word, input int n_pay,
                          input int delay, input logic [7:0] reply, input int rst_after);
    bit         is_rd;
    logic [7:0] exp_bits;
    is_rd = dir && m_seen;
    SS_n = 1'b0; MOSI = 1'($urandom); tick();
    MOSI = dir; tick();
    for (int i = 0; i < n_pay; i++) begin
      MOSI     = word[9-i];
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      check("rx_valid_early", {15'd0, rx_valid}, 16'd0);
      tick();
    end
    if (n_pay < 10) begin
      SS_n = 1'b1; tx_valid = 1'b0; tick();
      check("abort_rx_valid", {15'd0, rx_valid}, 16'd0);
      check("abort_rx_hold", {6'd0, rx_data}, {6'd0, m_last_rx});
      check("abort_miso", {15'd0, MISO}, 16'd0);
`ifdef SPI_FRAME_ERR_EN
      check("abort_frame_err", {15'd0, frame_err}, 16'd1);
      tick();
      check("frame_err_pulse", {15'd0, frame_err}, 16'd0);
`endif
      return;
    end
    tx_valid = 1'b0;
    check("rx_valid_strobe", {15'd0, rx_valid}, 16'd1);
    check("rx_data", {6'd0, rx_data}, {6'd0, word});
    m_last_rx = word;
    if (dir && !m_seen) m_seen = 1'b1;
    for (int k = 0; k < delay; k++) begin
      tick();
      check("wait_miso", {15'd0, MISO}, 16'd0);
      check("wait_rx_valid", {15'd0, rx_valid}, 16'd0);
    end
    tx_valid = 1'b1; tx_data = reply; tick();
    tx_valid = 1'b0; tx_data = 8'($urandom);
    exp_bits = is_rd ? reply : 8'h00;
    for (int b = 7; b >= 0; b--) begin
      check("miso_bit", {15'd0, MISO}, {15'd0, exp_bits[b]});
      if (is_rd && rst_after == 8 - b) begin
        #1 rst_n = 1'b0;
        #1;
        m_seen = 1'b0;
        m_last_rx = 10'd0;
        check("rst_miso", {15'd0, MISO}, 16'd0);
        check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
        check("rst_rx_data", {6'd0, rx_data}, 16'd0);
        SS_n = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        return;
      end
      if (b > 0) tick();
    end
    tick();
    check("miso_after_reply", {15'd0, MISO}, 16'd0);
    if (is_rd) m_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      MOSI     = 1'($urandom);
      tick();
      check("hold_miso", {15'd0, MISO}, 16'd0);
      check("hold_rx_valid", {15'd0, rx_valid}, 16'd0);
    end
    tx_valid = 1'b0;
    SS_n = 1'b1; tick();
`ifdef SPI_FRAME_ERR_EN
    check("clean_end_frame_err", {15'd0, frame_err}, 16'd0);
`endif
    check("end_miso", {15'd0, MISO}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    m_seen = 1'b0; m_last_rx = 10'd0;
    #1;
    check("reset_miso", {15'd0, MISO}, 16'd0);
    check("reset_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("reset_rx_data", {6'd0, rx_data}, 16'd0);
`ifdef SPI_FRAME_ERR_EN
    check("reset_frame_err", {15'd0, frame_err}, 16'd0);
`endif
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Write, read-address, read-data with prompt reply.
    do_frame(1'b0, 10'h005, 10, 1, 8'h5A, -1);
    do_frame(1'b1, 10'h205, 10, 1, 8'hFF, -1);
    do_frame(1'b1, 10'h300, 10, 1, 8'hA5, -1);
    // Abort after 5 payload bits, then a full frame.
    do_frame(1'b0, 10'h0F3, 5, 1, 8'h00, -1);
    do_frame(1'b0, 10'h0C3, 10, 1, 8'h00, -1);
    // Stalled reply.
    do_frame(1'b1, 10'h211, 10, 1, 8'h00, -1);
    do_frame(1'b1, 10'h311, 10, 7, 8'h3C, -1);
    // Reset after 3 reply bits; next read frame must be a read-address frame.
    do_frame(1'b1, 10'h222, 10, 1, 8'h00, -1);
    do_frame(1'b1, 10'h322, 10, 1, 8'hC6, 3);
    do_frame(1'b1, 10'h333, 10, 1, 8'h99, -1);
    do_frame(1'b1, 10'h344, 10, 2, 8'h81, -1);

    for (int n = 0; n < 30; n++) begin
      automatic bit         dir   = 1'($urandom);
      automatic logic [9:0] word  = 10'($urandom);
      automatic int         npay  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10;
      automatic int         delay = int'($urandom_range(1, 5));
      do_frame(dir, word, npay, delay, 8'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
